// File: rtl/chr_bg_ctrl_if.sv
// Bundle of the CPU write, fill, shadow-register and RAM-write signals of the
// background write controller.
interface chr_bg_ctrl_if #(
  parameter int LEN_BITS = 13
);
  // cpu_req is held high until cpu_ack; cpu_ack is a one-cycle pulse that
  // coincides with the RAM write strobe, so the request may drop after it.
  logic                cpu_req;
  logic                cpu_sel;
  logic [31:0]         cpu_addr;
  logic [7:0]          cpu_data;
  logic                cpu_ack;

  logic                fill_start;
  logic                fill_sel;
  logic [31:0]         fill_base;
  logic [LEN_BITS-1:0] fill_len;
  logic [7:0]          fill_value;
  logic                fill_busy;
  logic                fill_done;

  logic                reg_we;
  logic [1:0]          reg_sel;
  logic [31:0]         reg_data;
  logic                frame_start;

  logic [31:0]         chr_address;
  logic [7:0]          chr_din;
  logic                chr_we;
  logic [31:0]         bitmap_address;
  logic [7:0]          bitmap_din;
  logic                bitmap_we;
  logic [31:0]         x;
  logic [31:0]         y;
  logic [31:0]         scale;

  modport master (
    output cpu_req, cpu_sel, cpu_addr, cpu_data,
    output fill_start, fill_sel, fill_base, fill_len, fill_value,
    output reg_we, reg_sel, reg_data, frame_start,
    input  cpu_ack, fill_busy, fill_done,
    input  chr_address, chr_din, chr_we, bitmap_address, bitmap_din, bitmap_we,
    input  x, y, scale
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_addr, cpu_data,
    input  fill_start, fill_sel, fill_base, fill_len, fill_value,
    input  reg_we, reg_sel, reg_data, frame_start,
    output cpu_ack, fill_busy, fill_done,
    output chr_address, chr_din, chr_we, bitmap_address, bitmap_din, bitmap_we,
    output x, y, scale
  );
endinterface

// File: rtl/chr_bg_ctrl.sv
// Background-layer write controller: arbitrates CPU and fill-engine writes into
// one registered write stage and frame-synchronises the scroll/scale registers.
module chr_bg_ctrl #(
  parameter int CHR_SIZE_BITS = 6,
  parameter int LEN_BITS      = 13
) (
  input  logic          clk,
  input  logic          reset,
  chr_bg_ctrl_if.slave  bus,
  output logic          fill_state_o
);
  localparam int ADDR_BITS = 2 * CHR_SIZE_BITS;

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_e;

  state_e                state_q, state_d;
  logic                  f_sel_q, f_sel_d;
  logic [ADDR_BITS-1:0]  f_addr_q, f_addr_d;
  logic [LEN_BITS-1:0]   f_cnt_q, f_cnt_d;
  logic [7:0]            f_val_q, f_val_d;

  logic                  chr_we_q, chr_we_d;
  logic [ADDR_BITS-1:0]  chr_addr_q, chr_addr_d;
  logic [7:0]            chr_din_q, chr_din_d;
  logic                  bm_we_q, bm_we_d;
  logic [ADDR_BITS-1:0]  bm_addr_q, bm_addr_d;
  logic [7:0]            bm_din_q, bm_din_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  done_q, done_d;
  logic                  last_pend_q, last_pend_d;

  logic [31:0]           sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_s_q, sh_s_d;
  logic [31:0]           x_q, x_d, y_q, y_d, s_q, s_d;

  logic                  grant_cpu, grant_fill, fill_last, busy, start_ok;
  logic                  wr_sel;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [7:0]            wr_data;
  logic                  unused_bits;

  // cpu_ack high blocks the CPU for a cycle: no double write of a held
  // request, and the fill engine is guaranteed every other slot.
  assign grant_cpu  = bus.cpu_req && !cpu_ack_q;
  assign grant_fill = !grant_cpu && (state_q == S_FILL);
  assign fill_last  = grant_fill && (f_cnt_q == LEN_BITS'(1));
  assign busy       = (state_q == S_FILL) || last_pend_q;
  assign start_ok   = bus.fill_start && !busy;

  always_comb begin
    state_d     = state_q;
    f_sel_d     = f_sel_q;
    f_addr_d    = f_addr_q;
    f_cnt_d     = f_cnt_q;
    f_val_d     = f_val_q;
    done_d      = fill_last;
    last_pend_d = fill_last;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (bus.fill_len != '0) begin
            state_d  = S_FILL;
            f_sel_d  = bus.fill_sel;
            f_addr_d = bus.fill_base[ADDR_BITS-1:0];
            f_cnt_d  = bus.fill_len;
            f_val_d  = bus.fill_value;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (grant_fill) begin
          f_addr_d = f_addr_q + ADDR_BITS'(1);
          f_cnt_d  = f_cnt_q - LEN_BITS'(1);
          if (fill_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_sel  = f_sel_q;
    wr_addr = f_addr_q;
    wr_data = f_val_q;
    if (grant_cpu) begin
      wr_sel  = bus.cpu_sel;
      wr_addr = bus.cpu_addr[ADDR_BITS-1:0];
      wr_data = bus.cpu_data;
    end
    chr_we_d   = (grant_cpu || grant_fill) && !wr_sel;
    bm_we_d    = (grant_cpu || grant_fill) && wr_sel;
    chr_addr_d = chr_we_d ? wr_addr : chr_addr_q;
    chr_din_d  = chr_we_d ? wr_data : chr_din_q;
    bm_addr_d  = bm_we_d ? wr_addr : bm_addr_q;
    bm_din_d   = bm_we_d ? wr_data : bm_din_q;
    cpu_ack_d  = grant_cpu;
  end

  // Live copies sample the shadows before this cycle's register write lands.
  always_comb begin
    sh_x_d = sh_x_q;
    sh_y_d = sh_y_q;
    sh_s_d = sh_s_q;
    x_d    = bus.frame_start ? sh_x_q : x_q;
    y_d    = bus.frame_start ? sh_y_q : y_q;
    s_d    = bus.frame_start ? sh_s_q : s_q;
    if (bus.reg_we) begin
      case (bus.reg_sel)
        2'd0:    sh_x_d = bus.reg_data;
        2'd1:    sh_y_d = bus.reg_data;
        2'd2:    sh_s_d = bus.reg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      f_sel_q     <= 1'b0;
      f_addr_q    <= '0;
      f_cnt_q     <= '0;
      f_val_q     <= '0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= '0;
      chr_din_q   <= '0;
      bm_we_q     <= 1'b0;
      bm_addr_q   <= '0;
      bm_din_q    <= '0;
      cpu_ack_q   <= 1'b0;
      done_q      <= 1'b0;
      last_pend_q <= 1'b0;
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_s_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      f_sel_q     <= f_sel_d;
      f_addr_q    <= f_addr_d;
      f_cnt_q     <= f_cnt_d;
      f_val_q     <= f_val_d;
      chr_we_q    <= chr_we_d;
      chr_addr_q  <= chr_addr_d;
      chr_din_q   <= chr_din_d;
      bm_we_q     <= bm_we_d;
      bm_addr_q   <= bm_addr_d;
      bm_din_q    <= bm_din_d;
      cpu_ack_q   <= cpu_ack_d;
      done_q      <= done_d;
      last_pend_q <= last_pend_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_s_q      <= sh_s_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
    end
  end

  assign bus.cpu_ack        = cpu_ack_q;
  assign bus.fill_busy      = busy;
  assign bus.fill_done      = done_q;
  assign bus.chr_we         = chr_we_q;
  assign bus.chr_address    = {{(32-ADDR_BITS){1'b0}}, chr_addr_q};
  assign bus.chr_din        = chr_din_q;
  assign bus.bitmap_we      = bm_we_q;
  assign bus.bitmap_address = {{(32-ADDR_BITS){1'b0}}, bm_addr_q};
  assign bus.bitmap_din     = bm_din_q;
  assign bus.x              = x_q;
  assign bus.y              = y_q;
  assign bus.scale          = s_q;
  assign fill_state_o       = (state_q == S_FILL);

  assign unused_bits = ^{bus.cpu_addr[31:ADDR_BITS], bus.fill_base[31:ADDR_BITS]};
endmodule

// File: tb/tb_chr_bg_ctrl.sv
// Directed bench for chr_bg_ctrl: CPU write, wrapping fill, arbitration under
// a held CPU request, zero-length/ignored fills, shadow commit and reset abort.
module tb_chr_bg_ctrl;
  logic clk;
  logic reset;
  logic fill_state;
  int   n_cmp;
  int   n_err;

  chr_bg_ctrl_if #(.LEN_BITS(13)) bus ();

  chr_bg_ctrl #(.CHR_SIZE_BITS(6), .LEN_BITS(13)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .fill_state_o (fill_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs checked there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_ports(input string tag);
    chk({tag, "_chr_we"}, 32'(bus.chr_we), 32'(0));
    chk({tag, "_bm_we"}, 32'(bus.bitmap_we), 32'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.cpu_req = 0; bus.cpu_sel = 0; bus.cpu_addr = 0; bus.cpu_data = 0;
    bus.fill_start = 0; bus.fill_sel = 0; bus.fill_base = 0; bus.fill_len = 0;
    bus.fill_value = 0; bus.reg_we = 0; bus.reg_sel = 0; bus.reg_data = 0;
    bus.frame_start = 0;
    step();
    step();

    // reset state
    chk_idle_ports("rst");
    chk("rst_ack", 32'(bus.cpu_ack), 32'(0));
    chk("rst_busy", 32'(bus.fill_busy), 32'(0));
    chk("rst_done", 32'(bus.fill_done), 32'(0));
    chk("rst_state", 32'(fill_state), 32'(0));
    chk("rst_x", bus.x, 32'd0);
    chk("rst_chr_addr", bus.chr_address, 32'd0);
    reset = 1'b1;
    step();

    // single CPU write to the name table
    bus.cpu_req = 1; bus.cpu_sel = 0; bus.cpu_addr = 32'h0000_0005; bus.cpu_data = 8'h3C;
    step();
    chk("cpu_we", 32'(bus.chr_we), 32'(1));
    chk("cpu_addr", bus.chr_address, 32'h5);
    chk("cpu_din", 32'(bus.chr_din), 32'h3C);
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(1));
    chk("cpu_bm_we", 32'(bus.bitmap_we), 32'(0));
    bus.cpu_req = 0;
    step();
    chk_idle_ports("cpu_once");
    chk("cpu_ack_drop", 32'(bus.cpu_ack), 32'(0));
    chk("cpu_addr_hold", bus.chr_address, 32'h5);

    // bitmap fill across the address wrap
    bus.fill_start = 1; bus.fill_sel = 1; bus.fill_base = 32'h0000_0FFE;
    bus.fill_len = 13'd4; bus.fill_value = 8'h02;
    step();
    bus.fill_start = 0;
    chk("f4_busy0", 32'(bus.fill_busy), 32'(1));
    chk("f4_we0", 32'(bus.bitmap_we), 32'(0));
    for (int i = 0; i < 4; i++) begin
      logic [11:0] ea;
      ea = 12'hFFE + 12'(i);
      step();
      chk("f4_we", 32'(bus.bitmap_we), 32'(1));
      chk("f4_addr", bus.bitmap_address, 32'(ea));
      chk("f4_din", 32'(bus.bitmap_din), 32'h02);
      chk("f4_chr_we", 32'(bus.chr_we), 32'(0));
      chk("f4_done", 32'(bus.fill_done), 32'(i == 3));
      chk("f4_busy", 32'(bus.fill_busy), 32'(1));
    end
    step();
    chk_idle_ports("f4_end");
    chk("f4_busy_end", 32'(bus.fill_busy), 32'(0));
    chk("f4_done_end", 32'(bus.fill_done), 32'(0));
    chk("f4_addr_hold", bus.bitmap_address, 32'h001);

    // len=8 fill to the name table while the CPU keeps requesting bitmap writes
    bus.cpu_req = 1; bus.cpu_sel = 1; bus.cpu_addr = 32'h200; bus.cpu_data = 8'h50;
    bus.fill_start = 1; bus.fill_sel = 0; bus.fill_base = 32'h100;
    bus.fill_len = 13'd8; bus.fill_value = 8'hAA;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) bus.fill_start = 0;
      if (k % 2 == 0) begin
        chk("arb_cpu_we", 32'(bus.bitmap_we), 32'(1));
        chk("arb_cpu_addr", bus.bitmap_address, 32'h200 + 32'(k / 2));
        chk("arb_cpu_din", 32'(bus.bitmap_din), 32'h50 + 32'(k / 2));
        chk("arb_cpu_ack", 32'(bus.cpu_ack), 32'(1));
        chk("arb_cpu_chr", 32'(bus.chr_we), 32'(0));
        bus.cpu_addr = 32'h200 + 32'(k / 2 + 1);
        bus.cpu_data = 8'(8'h50 + k / 2 + 1);
      end else begin
        chk("arb_fill_we", 32'(bus.chr_we), 32'(1));
        chk("arb_fill_addr", bus.chr_address, 32'h100 + 32'((k - 1) / 2));
        chk("arb_fill_din", 32'(bus.chr_din), 32'hAA);
        chk("arb_fill_bm", 32'(bus.bitmap_we), 32'(0));
        chk("arb_fill_ack", 32'(bus.cpu_ack), 32'(0));
      end
      chk("arb_done", 32'(bus.fill_done), 32'(k == 15));
    end
    bus.cpu_req = 0;
    step();
    chk_idle_ports("arb_end");
    chk("arb_busy_end", 32'(bus.fill_busy), 32'(0));
    chk("arb_done_end", 32'(bus.fill_done), 32'(0));

    // zero-length fill
    bus.fill_start = 1; bus.fill_sel = 0; bus.fill_base = 32'h040; bus.fill_len = 13'd0;
    step();
    bus.fill_start = 0;
    chk("z_done", 32'(bus.fill_done), 32'(1));
    chk("z_busy", 32'(bus.fill_busy), 32'(0));
    chk_idle_ports("z");
    step();
    chk("z_done_drop", 32'(bus.fill_done), 32'(0));
    chk("z_busy2", 32'(bus.fill_busy), 32'(0));
    chk_idle_ports("z2");

    // fill_start during an active fill is ignored
    bus.fill_start = 1; bus.fill_sel = 0; bus.fill_base = 32'h010;
    bus.fill_len = 13'd3; bus.fill_value = 8'h11;
    step();
    bus.fill_start = 0;
    step();
    chk("ign_addr0", bus.chr_address, 32'h010);
    bus.fill_start = 1; bus.fill_sel = 1; bus.fill_base = 32'h800;
    bus.fill_len = 13'd5; bus.fill_value = 8'h77;
    step();
    bus.fill_start = 0;
    chk("ign_addr1", bus.chr_address, 32'h011);
    chk("ign_din1", 32'(bus.chr_din), 32'h11);
    chk("ign_bm1", 32'(bus.bitmap_we), 32'(0));
    step();
    chk("ign_addr2", bus.chr_address, 32'h012);
    chk("ign_done", 32'(bus.fill_done), 32'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_ports("ign_after");
      chk("ign_no_done", 32'(bus.fill_done), 32'(0));
      chk("ign_busy", 32'(bus.fill_busy), 32'(0));
    end

    // shadow registers and frame commit
    bus.reg_we = 1; bus.reg_sel = 2'd0; bus.reg_data = 32'd7;
    step();
    bus.reg_we = 0;
    chk("sh_x_pre", bus.x, 32'd0);
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    chk("sh_x7", bus.x, 32'd7);
    bus.reg_we = 1; bus.reg_sel = 2'd0; bus.reg_data = 32'd100; bus.frame_start = 1;
    step();
    bus.reg_we = 0; bus.frame_start = 0;
    chk("sh_same_cycle", bus.x, 32'd7);
    bus.reg_we = 1; bus.reg_sel = 2'd1; bus.reg_data = 32'h20;
    step();
    bus.reg_sel = 2'd2; bus.reg_data = 32'h3;
    step();
    bus.reg_sel = 2'd3; bus.reg_data = 32'hDEAD;
    step();
    bus.reg_we = 0;
    chk("sh_y_pre", bus.y, 32'd0);
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    chk("sh_x100", bus.x, 32'd100);
    chk("sh_y", bus.y, 32'h20);
    chk("sh_scale", bus.scale, 32'h3);

    // reset in the middle of a len=16 fill
    bus.fill_start = 1; bus.fill_sel = 1; bus.fill_base = 32'h400;
    bus.fill_len = 13'd16; bus.fill_value = 8'h09;
    step();
    bus.fill_start = 0;
    step();
    step();
    step();
    chk("mid_we", 32'(bus.bitmap_we), 32'(1));
    chk("mid_addr", bus.bitmap_address, 32'h402);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_idle_ports("ab");
    chk("ab_busy", 32'(bus.fill_busy), 32'(0));
    chk("ab_done", 32'(bus.fill_done), 32'(0));
    chk("ab_x", bus.x, 32'd0);
    chk("ab_y", bus.y, 32'd0);
    chk("ab_scale", bus.scale, 32'd0);
    chk("ab_bm_addr", bus.bitmap_address, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle_ports("ab_after");
      chk("ab_no_done", 32'(bus.fill_done), 32'(0));
      chk("ab_no_busy", 32'(bus.fill_busy), 32'(0));
    end
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    chk("ab_shadow_clr", bus.x, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/chr_bg_ctrl.md
# chr_bg_ctrl

Write-side controller for the tiled background layer. It shares the name-table and bitmap RAM write ports between a CPU requester and an internal fill engine, and it drives the scroll and scale registers. Scroll and scale are held as shadow copies and committed only on a frame-start pulse, so a scroll change never tears mid-frame. Everything runs in the `clk` domain; the background block's own CDC handles the crossing to the video clock.

## Interface
Parameters:
- `CHR_SIZE_BITS`, default 6: log2 of tiles per row; RAM address width `ADDR_BITS` = 2*`CHR_SIZE_BITS`.
- `LEN_BITS`, default 13: width of the fill length (max 4096 words).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `cpu_req`  in  1  CPU write request; held high until `cpu_ack`.
- `cpu_sel`  in  1  target of the CPU write: 0 = name table, 1 = bitmap.
- `cpu_addr`  in  32  CPU word address; low `ADDR_BITS` used.
- `cpu_data`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle acknowledge, coincident with the write strobe.
- `fill_start`  in  1  one-cycle pulse that starts a fill.
- `fill_sel`  in  1  fill target: 0 = name table, 1 = bitmap.
- `fill_base`  in  32  first fill address; low `ADDR_BITS` used.
- `fill_len`  in  `LEN_BITS`  number of words to write.
- `fill_value`  in  8  value written to every word.
- `fill_busy`  out  1  high while a fill is in progress.
- `fill_done`  out  1  one-cycle completion pulse.
- `reg_we`  in  1  shadow register write strobe.
- `reg_sel`  in  2  shadow register select: 0 = x, 1 = y, 2 = scale, 3 = reserved (write ignored).
- `reg_data`  in  32  shadow register write data.
- `frame_start`  in  1  one-cycle pulse at frame start; commits the shadows.
- `chr_address`  out  32  name-table write address.
- `chr_din`  out  8  name-table write data.
- `chr_we`  out  1  name-table write enable.
- `bitmap_address`  out  32  bitmap write address.
- `bitmap_din`  out  8  bitmap write data.
- `bitmap_we`  out  1  bitmap write enable.
- `x`, `y`, `scale`  out  32 each  live scroll offsets and scale.

## Operation
Write arbitration:
- A single registered write stage feeds both RAM ports.
- Each cycle, at most one source is granted. CPU has priority when `cpu_req`=1 and `cpu_ack` is not high in that cycle. Otherwise the fill engine is granted if it is in FILL. Otherwise nothing is granted.
- A grant in cycle N produces, in cycle N+1:
  - the selected `*_we`=1, with `*_address` = {zeros, addr[`ADDR_BITS`-1:0]} and `*_din` = data;
  - the non-selected port's `we`=0.
- A CPU grant additionally raises `cpu_ack` in cycle N+1.
- Because CPU is never granted while `cpu_ack` is high, a held `cpu_req` is not written twice. It also caps CPU at 1 write per 2 cycles, so the fill engine gets at least 50% of slots while a fill is active.
- Address and data outputs hold their last values when `we`=0.

Fill FSM (IDLE, FILL):
- IDLE: on `fill_start` with `fill_len`≠0, latch sel, base, len and value, then go to FILL. On `fill_start` with `fill_len`=0, pulse `fill_done` in the next cycle and stay in IDLE.
- FILL: each granted cycle writes the current address, then increments the address mod 2^`ADDR_BITS` (wraps from 4095 to 0) and decrements the remaining count. The grant that writes the last word returns the FSM to IDLE.
- `fill_done` is asserted in the same cycle as the last word's `we`.
- `fill_busy` = (state==FILL) OR (last fill write pending in the write stage). It falls in the cycle after `fill_done`.
- `fill_start` while busy is ignored: no latch, no done.

Shadow registers:
- `reg_we` writes the shadow selected by `reg_sel`.
- `frame_start` copies all three shadows into `x`/`y`/`scale` in the next cycle.
- If `reg_we` and `frame_start` occur in the same cycle, the live copy takes the pre-write shadow value. The new value is committed at the next `frame_start`.

Reset (`reset`=0 at a clock edge):
- FSM returns to IDLE and any in-progress fill is aborted with no `fill_done`.
- All `we`, `cpu_ack`, `fill_busy` and `fill_done` go to 0.
- Addresses, din, shadows, `x`, `y` and `scale` go to 0.

## Timing
- CPU write latency: 1 cycle from grant to strobe and `cpu_ack`. Minimum CPU write spacing is 2 cycles.
- Fill with no CPU traffic: `fill_start` at cycle S gives writes in cycles S+2 .. S+1+len. `fill_done` is at S+1+len. `fill_busy` is high from S+1 through S+1+len.
- Scroll commit: live outputs change exactly 1 cycle after `frame_start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then a CPU write with sel=0, addr=0x005, data=0x3C → `chr_we`=1, `chr_address`=5, `chr_din`=0x3C and `cpu_ack`=1, all in the same cycle, exactly once; `bitmap_we`=0 throughout.
- Fill with sel=1, base=0xFFE, len=4, value=0x02 and no CPU traffic → `bitmap_we` on 4 consecutive cycles at addresses 0xFFE, 0xFFF, 0x000, 0x001; `fill_done` on the 4th.
- Fill with len=8 while `cpu_req` is held continuously → writes alternate between CPU and fill; exactly 8 fill writes; no CPU write is duplicated.
- Fill with len=0 → `fill_done` one cycle later, no `we`, `fill_busy` stays 0. A `fill_start` during an active fill is ignored.
- `reg_we` x=100 in the same cycle as `frame_start` (old shadow 7) → `x`=7. At the next `frame_start`, `x`=100.
- Assert `reset`=0 midway through a len=16 fill → next cycle: `we`=0, `fill_busy`=0, no `fill_done`, `x`/`y`/`scale`=0.
